// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage. Holds the PC, issues fetch requests to the
// i-cache, and supplies decode with the predicted next address plus a
// "taken branch" flag from a small direct-mapped branch target buffer (BTB)
// that execute trains. Handles decode backpressure, i-cache misses and
// execute redirects.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   address             fetch address (the PC register)
//   req_valid           fetch request valid
//   data_valid          i-cache delivered data for the held address (miss wait)
//   cache_miss          i-cache cannot serve the current request this cycle
//   predicted_next_adr  predicted address following address
//   branch_jump         BTB hit: predicted_next_adr is a taken target
//   stall               decode backpressure
//   redirect_valid/adr  execute flush / mispredict and its new PC
//   btb_upd_*           BTB training strobe, branch PC, target, taken flag
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int                   ADR_WIDTH    = 32,
  parameter int                   RETURN_BYTES = 4,
  parameter logic [ADR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                   BTB_ENTRIES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADR_WIDTH-1:0] address,
  output logic                 req_valid,
  input  logic                 data_valid,
  input  logic                 cache_miss,
  output logic [ADR_WIDTH-1:0] predicted_next_adr,
  output logic                 branch_jump,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [ADR_WIDTH-1:0] redirect_adr,
  input  logic                 btb_upd_valid,
  input  logic [ADR_WIDTH-1:0] btb_upd_pc,
  input  logic [ADR_WIDTH-1:0] btb_upd_target,
  input  logic                 btb_upd_taken
);

  localparam int OFF_W = $clog2(RETURN_BYTES);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADR_WIDTH - OFF_W - IDX_W;

  localparam logic [ADR_WIDTH-1:0] STEP       = ADR_WIDTH'(RETURN_BYTES);
  localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ~(ADR_WIDTH'(RETURN_BYTES - 1));

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_MISS  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ADR_WIDTH-1:0] pc_q, pc_d;

  // BTB storage: valid bits need a reset, tag/target do not.
  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  logic [ADR_WIDTH-1:0]   btb_target_q [BTB_ENTRIES];

  // -------------------------------------------------------------------------
  // Lookup on the current PC
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  assign look_idx = pc_q[OFF_W +: IDX_W];
  assign look_tag = pc_q[ADR_WIDTH-1 -: TAG_W];
  assign look_hit = btb_valid_q[look_idx] && (btb_tag_q[look_idx] == look_tag);

  assign address            = pc_q;
  assign branch_jump        = look_hit;
  assign predicted_next_adr = look_hit ? btb_target_q[look_idx] : (pc_q + STEP);

  assign req_valid = ((state_q == ST_FETCH) || (state_q == ST_MISS)) && !stall;

  // -------------------------------------------------------------------------
  // Training: per-entry set/clear strobes
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]       upd_idx;
  logic [TAG_W-1:0]       upd_tag;
  logic [BTB_ENTRIES-1:0] ent_set;
  logic [BTB_ENTRIES-1:0] ent_clr;

  assign upd_idx = btb_upd_pc[OFF_W +: IDX_W];
  assign upd_tag = btb_upd_pc[ADR_WIDTH-1 -: TAG_W];

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb_strobe
    logic sel;
    assign sel         = btb_upd_valid && (upd_idx == IDX_W'(gi));
    // Taken overwrites whatever aliases into the slot; not-taken only
    // invalidates the slot if it actually belongs to this branch.
    assign ent_set[gi] = sel && btb_upd_taken;
    assign ent_clr[gi] = sel && !btb_upd_taken && (btb_tag_q[gi] == upd_tag);
  end

  // -------------------------------------------------------------------------
  // PC / state next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      // Redirect wins in every state, including RST and a pending miss.
      pc_d    = redirect_adr & ALIGN_MASK;
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_RST: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (stall) begin
            state_d = ST_FETCH;
          end else if (cache_miss) begin
            state_d = ST_MISS;
          end else begin
            pc_d = predicted_next_adr;
          end
        end
        ST_MISS: begin
          if (!stall && data_valid) begin
            pc_d    = predicted_next_adr;
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_RST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST;
      pc_q        <= RESET_VECTOR;
      btb_valid_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        if (ent_set[i]) begin
          btb_valid_q[i]  <= 1'b1;
          btb_tag_q[i]    <= upd_tag;
          btb_target_q[i] <= btb_upd_target;
        end else if (ent_clr[i]) begin
          btb_valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed vector table (hand-derived expectations) followed by randomized
// traffic checked against a behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic        req_valid;
  logic        data_valid;
  logic        cache_miss;
  logic [31:0] predicted_next_adr;
  logic        branch_jump;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_adr;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic        btb_upd_taken;

  if_fetch_stage dut (
    .clk                (clk),
    .rst                (rst),
    .address            (address),
    .req_valid          (req_valid),
    .data_valid         (data_valid),
    .cache_miss         (cache_miss),
    .predicted_next_adr (predicted_next_adr),
    .branch_jump        (branch_jump),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_adr       (redirect_adr),
    .btb_upd_valid      (btb_upd_valid),
    .btb_upd_pc         (btb_upd_pc),
    .btb_upd_target     (btb_upd_target),
    .btb_upd_taken      (btb_upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r, s, m, d;
    bit          rv;
    logic [31:0] ra;
    bit          uv;
    logic [31:0] up, ut;
    bit          tk;
    bit          chk;
    logic [31:0] ea;
    bit          er;
    logic [31:0] ep;
    bit          eb;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 = just reset, 1 = fetching, 2 = waiting on a miss
  int          mode_m;
  logic [31:0] pc_m;
  bit          bhas[8];
  logic [31:0] bpc[8];
  logic [31:0] btgt[8];

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 8);
  endfunction

  function automatic void model_out(output logic [31:0] p, output bit bj);
    int k = slot(pc_m);
    if (bhas[k] && ((bpc[k] >> 2) == (pc_m >> 2))) begin
      p  = btgt[k];
      bj = 1'b1;
    end else begin
      p  = pc_m + 32'd4;
      bj = 1'b0;
    end
  endfunction

  task automatic model_step(input vec_t v);
    logic [31:0] p;
    bit          bj;
    int          k;
    model_out(p, bj);
    if (v.r) begin
      pc_m   = 32'h0;
      mode_m = 0;
      for (int i = 0; i < 8; i++) bhas[i] = 1'b0;
    end else begin
      if (v.uv) begin
        k = slot(v.up);
        if (v.tk) begin
          bhas[k] = 1'b1;
          bpc[k]  = v.up;
          btgt[k] = v.ut;
        end else if (bhas[k] && ((bpc[k] >> 2) == (v.up >> 2))) begin
          bhas[k] = 1'b0;
        end
      end
      if (v.rv) begin
        pc_m   = {v.ra[31:2], 2'b00};
        mode_m = 1;
      end else if (mode_m == 0) begin
        mode_m = 1;
      end else if (mode_m == 1) begin
        if (!v.s && v.m)       mode_m = 2;
        else if (!v.s)         pc_m   = p;
      end else begin
        if (!v.s && v.d) begin
          pc_m   = p;
          mode_m = 1;
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, s, m, d, input bit rv, input logic [31:0] ra,
                     input bit uv, input logic [31:0] up, ut, input bit tk,
                     input bit chk, input logic [31:0] ea, input bit er,
                     input logic [31:0] ep, input bit eb);
    vec_t v;
    v.r = r; v.s = s; v.m = m; v.d = d; v.rv = rv; v.ra = ra;
    v.uv = uv; v.up = up; v.ut = ut; v.tk = tk;
    v.chk = chk; v.ea = ea; v.er = er; v.ep = ep; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst            = v.r;
    stall          = v.s;
    cache_miss     = v.m;
    data_valid     = v.d;
    redirect_valid = v.rv;
    redirect_adr   = v.ra;
    btb_upd_valid  = v.uv;
    btb_upd_pc     = v.up;
    btb_upd_target = v.ut;
    btb_upd_taken  = v.tk;
  endtask

  initial begin
    vec_t        v;
    logic [31:0] mp;
    bit          mb;

    drive('{default: 0});
    mode_m = 0;
    pc_m   = 0;

    //  r s m d  rv ra            uv up      ut        tk chk addr          req pred          bj
    add(1,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 0, 32'h0,        0, 32'h0,        0); // 0 reset
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h0,        0, 32'h4,        0); // 1 RST
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h0,        1, 32'h4,        0); // 2
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h4,        1, 32'h8,        0); // 3
    add(0,0,1,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h8,        1, 32'hC,        0); // 4 miss
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h8,        1, 32'hC,        0); // 5
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h8,        1, 32'hC,        0); // 6
    add(0,0,0,1, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h8,        1, 32'hC,        0); // 7 data
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'hC,        1, 32'h10,       0); // 8
    add(0,1,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h10,       0, 32'h14,       0); // 9 stall
    add(0,1,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h10,       0, 32'h14,       0); // 10 stall
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h10,       1, 32'h14,       0); // 11
    add(0,0,0,0, 0,32'h0,        1,32'h20, 32'h100,  1, 1, 32'h14,       1, 32'h18,       0); // 12 train
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h18,       1, 32'h1C,       0); // 13
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h1C,       1, 32'h20,       0); // 14
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h20,       1, 32'h100,      1); // 15 hit
    add(0,0,0,0, 1,32'h20,       1,32'h20, 32'h100,  0, 1, 32'h100,      1, 32'h104,      0); // 16 untrain
    add(0,0,1,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h20,       1, 32'h24,       0); // 17 miss
    add(0,1,0,0, 1,32'h203,      0,32'h0,  32'h0,    0, 1, 32'h20,       0, 32'h24,       0); // 18 redir+stall
    add(0,1,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h200,      0, 32'h204,      0); // 19
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h200,      1, 32'h204,      0); // 20
    add(0,0,0,0, 0,32'h0,        1,32'h20, 32'h300,  1, 1, 32'h204,      1, 32'h208,      0); // 21
    add(0,0,0,0, 0,32'h0,        1,32'h60, 32'h400,  1, 1, 32'h208,      1, 32'h20C,      0); // 22 alias
    add(0,0,0,0, 1,32'h20,       0,32'h0,  32'h0,    0, 1, 32'h20C,      1, 32'h210,      0); // 23
    add(0,0,0,0, 1,32'hFFFFFFFC, 0,32'h0,  32'h0,    0, 1, 32'h20,       1, 32'h24,       0); // 24
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'hFFFFFFFC, 1, 32'h0,        0); // 25 wrap
    add(0,0,1,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h0,        1, 32'h4,        0); // 26 miss
    add(1,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h0,        1, 32'h4,        0); // 27 reset mid-miss
    add(0,0,0,0, 1,32'h40,       0,32'h0,  32'h0,    0, 1, 32'h0,        0, 32'h4,        0); // 28 RST+redir
    add(0,0,0,0, 1,32'h60,       0,32'h0,  32'h0,    0, 1, 32'h40,       1, 32'h44,       0); // 29
    add(0,0,0,0, 0,32'h0,        0,32'h0,  32'h0,    0, 1, 32'h60,       1, 32'h64,       0); // 30 btb cleared

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      drive(v);
      #1;
      if (v.chk) begin
        check($sformatf("vec%0d address", i),     address,            v.ea);
        check($sformatf("vec%0d req_valid", i),   {31'b0, req_valid},  {31'b0, v.er});
        check($sformatf("vec%0d predicted", i),   predicted_next_adr, v.ep);
        check($sformatf("vec%0d branch_jump", i), {31'b0, branch_jump}, {31'b0, v.eb});
      end
      $display("vec %0d: addr=%h req=%b pred=%h bj=%b", i, address, req_valid,
               predicted_next_adr, branch_jump);
      @(posedge clk);
      model_step(v);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      v = '{default: 0};
      v.r  = ($urandom_range(0, 199) == 0);
      v.s  = ($urandom_range(0, 3) == 0);
      v.m  = ($urandom_range(0, 3) == 0);
      v.d  = ($urandom_range(0, 4) < 2);
      v.rv = ($urandom_range(0, 11) == 0);
      v.ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 'h3FF));
      v.uv = ($urandom_range(0, 2) == 0);
      v.up = 32'($urandom_range(0, 'hFF));
      v.ut = 32'($urandom_range(0, 'h3FF)) & 32'hFFFF_FFFC;
      v.tk = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      drive(v);
      #1;
      model_out(mp, mb);
      check("rnd address",     address,                 pc_m);
      check("rnd req_valid",   {31'b0, req_valid},      {31'b0, (mode_m != 0) && !v.s});
      check("rnd predicted",   predicted_next_adr,      mp);
      check("rnd branch_jump", {31'b0, branch_jump},    {31'b0, mb});
      @(posedge clk);
      model_step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage. Holds the PC, issues requests on the i_cache_if fetch modport (address, req_valid), and produces predicted_next_adr and branch_jump for decode1.
- Contains a small direct-mapped branch target buffer (BTB) that execute trains.
- Handles decode backpressure, i-cache misses and execute redirects.

Parameters:
- ADR_WIDTH, 32, address/PC width.
- RETURN_BYTES, 4, bytes per fetch; PC step and alignment; power of 2.
- RESET_VECTOR, 32'h0000_0000, PC after reset.
- BTB_ENTRIES, 8, BTB depth; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- address  out  ADR_WIDTH  fetch address (equals PC register).
- req_valid  out  1  fetch request valid.
- data_valid  in  1  i-cache returned data for the held address (used in MISS_WAIT).
- cache_miss  in  1  i-cache cannot serve the current request this cycle.
- predicted_next_adr  out  ADR_WIDTH  predicted address following address.
- branch_jump  out  1  BTB hit; predicted_next_adr is a taken target.
- stall  in  1  decode backpressure.
- redirect_valid  in  1  execute flush/mispredict.
- redirect_adr  in  ADR_WIDTH  new PC on redirect.
- btb_upd_valid  in  1  BTB training strobe.
- btb_upd_pc  in  ADR_WIDTH  PC of the resolved branch.
- btb_upd_target  in  ADR_WIDTH  resolved target.
- btb_upd_taken  in  1  branch resolved taken.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Values on rst:
  - PC = RESET_VECTOR and state = RST.
  - All BTB valid bits cleared.
  - req_valid = 0, branch_jump = 0, predicted_next_adr = RESET_VECTOR + RETURN_BYTES.
- State RST: moves to FETCH on the next cycle unconditionally; req_valid = 0 while in RST.
- Outputs:
  - address = PC.
  - predicted_next_adr = BTB hit ? target : PC + RETURN_BYTES. The addition wraps modulo 2^ADR_WIDTH.
  - branch_jump = hit.
  - All three are combinational from the PC register and the BTB registers.
- req_valid = 1 in FETCH and MISS_WAIT when stall = 0; otherwise 0.
- FETCH, priority order:
  1. redirect_valid: PC <= redirect_adr with its low log2(RETURN_BYTES) bits cleared; stay in FETCH.
  2. stall: hold PC.
  3. cache_miss: hold PC; go to MISS_WAIT.
  4. Otherwise the request is accepted: PC <= predicted_next_adr.
- MISS_WAIT, priority order:
  1. redirect_valid: abandon the miss, load PC as in FETCH, go to FETCH.
  2. stall: hold PC and state.
  3. data_valid = 1: PC <= predicted_next_adr; go to FETCH.
  4. Otherwise hold.
- Redirect during RST: loads the PC and the next state is FETCH; redirect wins over the RST-to-FETCH default.
- BTB entry fields: valid, tag, target.
  - Index = pc[log2(RETURN_BYTES) +: log2(BTB_ENTRIES)].
  - Tag = pc[ADR_WIDTH-1 : log2(RETURN_BYTES)+log2(BTB_ENTRIES)].
  - Hit = valid && tag match.
- BTB training when btb_upd_valid = 1, using the entry indexed by btb_upd_pc:
  - Taken: entry <= {1, tag(btb_upd_pc), btb_upd_target}; overwrites any alias.
  - Not taken: valid cleared only if the tag matches; otherwise no change.
  - Writes happen at the clock edge, so a lookup in the same cycle sees the old contents.
- A BTB update concurrent with a redirect is applied independently.
- Reset mid-miss: returns to RST; the BTB is cleared.

Test Plan:
- Reset then run, stall = 0, cache_miss = 0:
  - Cycle 1: req_valid = 0.
  - Following cycles: address = 0x0, 0x4, 0x8 on consecutive cycles; branch_jump = 0; predicted_next_adr = address + 4.
- Miss at address 0x8 (cache_miss = 1 for one cycle, data_valid after 3 cycles):
  - address holds 0x8 throughout MISS_WAIT.
  - The cycle after data_valid, address = 0xC.
- Stall asserted for 2 cycles at address 0x10: req_valid = 0 and address = 0x10 for 2 cycles; then 0x14.
- Train btb_upd_pc = 0x20, target 0x100, taken = 1:
  - On reaching 0x20: branch_jump = 1, predicted_next_adr = 0x100; next address = 0x100.
  - Retrain with taken = 0: branch_jump = 0 at 0x20.
- Redirect versus stall and miss:
  - redirect_adr = 0x203 with stall = 1 in MISS_WAIT: next address = 0x200; state FETCH; req_valid = 0 until stall drops.
- Wrap and alias:
  - PC = 0xFFFF_FFFC, no hit: predicted_next_adr = 0x0.
  - Train 0x20 then alias 0x60 (BTB_ENTRIES = 8) taken: a lookup at 0x20 misses.
